// File: rtl/bus_arbiter_2m.sv
// Two-master, three-slave bus arbiter: fixed-priority grant FSM without preemption,
// shared slave bus muxed from the granted master, page-decoded selects and registered read-data steering.
module bus_arbiter_2m #(
  parameter logic [7:0] S0_PAGE = 8'h00,
  parameter logic [7:0] S1_PAGE = 8'h01,
  parameter logic [7:0] S2_PAGE = 8'h02
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_wr,
  input  logic        m1_wr,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m1_addr,
  input  logic [31:0] m0_dout,
  input  logic [31:0] m1_dout,
  output logic        m0_grant,
  output logic        m1_grant,
  output logic [31:0] m_din,
  output logic        s0_sel,
  output logic        s1_sel,
  output logic        s2_sel,
  output logic        s_wr,
  output logic [15:0] s_addr,
  output logic [31:0] s_din,
  input  logic [31:0] s0_dout,
  input  logic [31:0] s1_dout,
  input  logic [31:0] s2_dout
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 3;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [NS-1:0] dec_sel;
  logic [NS-1:0] rd_sel;
  logic [7:0]    s2_page_hi;

  assign s2_page_hi = 8'(S2_PAGE + 8'd1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: m0 wins from idle, current owner keeps the bus while requesting
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_req)      state_nxt = GNT0;
        else if (m1_req) state_nxt = GNT1;
      end
      GNT0: begin
        if (m0_req)      state_nxt = GNT0;
        else if (m1_req) state_nxt = GNT1;
        else             state_nxt = IDLE;
      end
      GNT1: begin
        if (m1_req)      state_nxt = GNT1;
        else if (m0_req) state_nxt = GNT0;
        else             state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m0_grant = (state == GNT0);
  assign m1_grant = (state == GNT1);

  // Shared slave bus follows the granted master, parked at zero when idle
  always_comb begin
    s_wr   = 1'b0;
    s_addr = {AW{1'b0}};
    s_din  = {DW{1'b0}};
    case (state)
      GNT0: begin
        s_wr   = m0_wr;
        s_addr = m0_addr;
        s_din  = m0_dout;
      end
      GNT1: begin
        s_wr   = m1_wr;
        s_addr = m1_addr;
        s_din  = m1_dout;
      end
      default: ;
    endcase
  end

  // Page decode; priority order keeps selects one-hot even if pages overlap
  always_comb begin
    dec_sel = {NS{1'b0}};
    if (state != IDLE) begin
      if (s_addr[15:8] == S0_PAGE)      dec_sel = 3'b001;
      else if (s_addr[15:8] == S1_PAGE) dec_sel = 3'b010;
      else if ((s_addr[15:8] == S2_PAGE) || (s_addr[15:8] == s2_page_hi))
                                        dec_sel = 3'b100;
    end
  end

  assign s0_sel = dec_sel[0];
  assign s1_sel = dec_sel[1];
  assign s2_sel = dec_sel[2];

  // Read select remembered for one cycle; writes steer nothing back
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     rd_sel <= {NS{1'b0}};
    else if (s_wr) rd_sel <= {NS{1'b0}};
    else           rd_sel <= dec_sel;
  end

  always_comb begin
    m_din = {DW{1'b0}};
    case (rd_sel)
      3'b001:  m_din = s0_dout;
      3'b010:  m_din = s1_dout;
      3'b100:  m_din = s2_dout;
      default: m_din = {DW{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Directed-vector bench for bus_arbiter_2m with hand-computed expectations.
module tb_bus_arbiter_2m;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_wr, m1_wr;
  logic [15:0] m0_addr, m1_addr;
  logic [31:0] m0_dout, m1_dout;
  logic        m0_grant, m1_grant;
  logic [31:0] m_din;
  logic        s0_sel, s1_sel, s2_sel, s_wr;
  logic [15:0] s_addr;
  logic [31:0] s_din;
  logic [31:0] s0_dout, s1_dout, s2_dout;

  int n_vec = 0;
  int n_bad = 0;

  bus_arbiter_2m dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_wr(m0_wr), .m1_wr(m1_wr),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_dout(m0_dout), .m1_dout(m1_dout),
    .m0_grant(m0_grant), .m1_grant(m1_grant), .m_din(m_din),
    .s0_sel(s0_sel), .s1_sel(s1_sel), .s2_sel(s2_sel),
    .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din),
    .s0_dout(s0_dout), .s1_dout(s1_dout), .s2_dout(s2_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gnts();
    return {30'd0, m1_grant, m0_grant};
  endfunction

  function automatic logic [31:0] sels();
    return {29'd0, s2_sel, s1_sel, s0_sel};
  endfunction

  initial begin
    reset = 1'b1;
    {m0_req, m1_req, m0_wr, m1_wr} = '0;
    m0_addr = '0; m1_addr = '0; m0_dout = '0; m1_dout = '0;
    s0_dout = 32'h1111_0000; s1_dout = 32'h2222_0000; s2_dout = 32'h3333_0000;
    #2;
    chk("rst_grants", gnts(), 32'd0);
    chk("rst_sels", sels(), 32'd0);
    chk("rst_mdin", m_din, 32'd0);
    step();
    step();
    reset = 1'b0;

    // First grant after reset, one-cycle latency
    m0_req = 1'b1;
    #1 chk("m0_pre_grant", gnts(), 32'd0);
    step();
    chk("m0_grant_lat1", gnts(), 32'b01);
    chk("idle_mdin", m_din, 32'd0);
    m0_req = 1'b0;
    step();
    chk("release_idle", gnts(), 32'd0);
    chk("idle_bus_wr", {31'd0, s_wr}, 32'd0);
    chk("idle_bus_addr", {16'd0, s_addr}, 32'd0);

    // Tie from idle goes to m0; m0 holds 4 cycles, then direct handover
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("tie_m0_hold", gnts(), 32'b01);
    end
    m0_req = 1'b0;
    step();
    chk("handover_m1", gnts(), 32'b10);

    // m1 writes slave 0
    m1_wr = 1'b1; m1_addr = 16'h0005; m1_dout = 32'h0000_0008;
    m0_addr = 16'h0300; m0_dout = 32'hDEAD_BEEF;
    #1;
    chk("wr_sels", sels(), 32'b001);
    chk("wr_s_wr", {31'd0, s_wr}, 32'd1);
    chk("wr_s_addr", {16'd0, s_addr}, 32'h0005);
    chk("wr_s_din", s_din, 32'h0000_0008);
    step();
    chk("wr_mdin_zero", m_din, 32'd0);

    // m0 waits while m1 holds, then takes over directly
    m0_req = 1'b1;
    step();
    chk("no_preempt", gnts(), 32'b10);
    m1_req = 1'b0; m1_wr = 1'b0;
    step();
    chk("handover_m0", gnts(), 32'b01);

    // m0 reads RAM upper page
    m0_wr = 1'b0; m0_addr = 16'h0300; s2_dout = 32'hCAFE_0001;
    #1;
    chk("rd_ram_sels", sels(), 32'b100);
    chk("rd_ram_addr", {16'd0, s_addr}, 32'h0300);
    step();
    chk("rd_ram_mdin", m_din, 32'hCAFE_0001);

    // m0 reads RAM base page and slave 1
    m0_addr = 16'h0210; s2_dout = 32'h0BAD_F00D;
    #1 chk("rd_ram_lo_sels", sels(), 32'b100);
    step();
    chk("rd_ram_lo_mdin", m_din, 32'h0BAD_F00D);
    m0_addr = 16'h0104; s1_dout = 32'h1234_5678;
    #1 chk("rd_s1_sels", sels(), 32'b010);
    step();
    chk("rd_s1_mdin", m_din, 32'h1234_5678);

    // Unmapped page
    m0_addr = 16'h0A00;
    #1 chk("unmapped_sels", sels(), 32'd0);
    step();
    chk("unmapped_mdin", m_din, 32'd0);

    // Switch to m1 writing, then assert reset mid-cycle
    m0_req = 1'b0; m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 16'h0005;
    step();
    chk("gnt1_again", gnts(), 32'b10);
    chk("gnt1_wr_sel", sels(), 32'b001);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_grants", gnts(), 32'd0);
    chk("async_rst_sels", sels(), 32'd0);
    chk("async_rst_wr", {31'd0, s_wr}, 32'd0);
    chk("async_rst_addr", {16'd0, s_addr}, 32'd0);
    chk("async_rst_din", s_din, 32'd0);
    chk("async_rst_mdin", m_din, 32'd0);
    m1_req = 1'b0; m1_wr = 1'b0;
    step();
    reset = 1'b0;

    // First grant after reset to m1 alone
    m1_req = 1'b1;
    #1 chk("post_rst_pre", gnts(), 32'd0);
    step();
    chk("post_rst_m1", gnts(), 32'b10);
    m1_req = 1'b0;
    step();
    chk("final_idle", gnts(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_2m.md
BUS_ARBITER_2M -- requirements
Module: bus_arbiter_2m

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have parameter S0_PAGE, default 8'h00, as the address page [15:8] of slave 0 (DMAC registers).
REQ-003 The block SHALL have parameter S1_PAGE, default 8'h01, as the address page of slave 1 (ALU instruction/operand FIFOs).
REQ-004 The block SHALL have parameter S2_PAGE, default 8'h02, as the base page of slave 2 (RAM), which spans S2_PAGE and S2_PAGE+1.
REQ-005 Port clk, input, 1, clock, rising edge.
REQ-006 Port reset, input, 1, asynchronous active-high reset.
REQ-007 Ports m0_req, m1_req, input, 1 each, bus requests (m0 = DMAC master, m1 = host master).
REQ-008 Ports m0_wr, m1_wr, input, 1 each, write (1) or read (0).
REQ-009 Ports m0_addr, m1_addr, input, 16 each, addresses.
REQ-010 Ports m0_dout, m1_dout, input, 32 each, write data.
REQ-011 Ports m0_grant, m1_grant, output, 1 each, registered grants.
REQ-012 Port m_din, output, 32, read data broadcast to both masters.
REQ-013 Ports s0_sel, s1_sel, s2_sel, output, 1 each, slave selects.
REQ-014 Ports s_wr, s_addr, s_din, output, 1/16/32, shared slave write strobe, address and write data.
REQ-015 Ports s0_dout, s1_dout, s2_dout, input, 32 each, slave read data.

Function
REQ-016 The arbiter SHALL be a registered FSM with states IDLE, GNT0, GNT1; m0_grant=1 only in GNT0 and m1_grant=1 only in GNT1.
REQ-017 In IDLE: m0_req=1 goes to GNT0 (m0 wins ties); else m1_req=1 goes to GNT1; else the FSM stays in IDLE.
REQ-018 In GNT0: m0_req=1 holds GNT0 (no preemption); m0_req=0 with m1_req=1 goes to GNT1; both 0 go to IDLE.
REQ-019 In GNT1 the rules SHALL mirror REQ-018 with masters swapped.
REQ-020 Grant latency SHALL be one cycle from request on an idle bus; grant release SHALL be one cycle after request drops.
REQ-021 Handover on simultaneous release and pending request SHALL be GNT0 to GNT1 (or reverse) directly, with no IDLE cycle and never both grants high.
REQ-022 s_wr, s_addr and s_din SHALL combinationally follow the granted master's wr, addr and dout; in IDLE they SHALL be 0.
REQ-023 Slave select SHALL be a combinational decode of s_addr[15:8] when a grant is active: S0_PAGE selects s0; S1_PAGE selects s1; S2_PAGE or S2_PAGE+1 selects s2.
REQ-024 In IDLE all selects SHALL be 0, and at most one select SHALL be high at any time.
REQ-025 An unmapped page SHALL assert no select; writes to it are dropped.
REQ-026 The read-data select SHALL be registered: the decode result of cycle N, taken only when s_wr=0, drives the m_din mux in cycle N+1 (read latency 1).
REQ-027 m_din SHALL be 32'h0 when the registered select is none (unmapped, write, or idle cycle).
REQ-028 m_din SHALL NOT depend on which master is granted; the requester samples it one cycle after issuing a read.

Reset
REQ-029 Asserting reset SHALL immediately force IDLE, both grants 0, all selects 0, s_wr/s_addr/s_din 0, registered read select none and m_din 0, including mid-transfer.
REQ-030 After reset deasserts, the first grant SHALL follow REQ-017 with one-cycle latency.

Verification
REQ-031 Reset; m0_req=1 at cycle 0 -> m0_grant=1 at cycle 1, m1_grant=0.
REQ-032 m0_req and m1_req rise in the same cycle from IDLE -> GNT0; m0 drops after 4 granted cycles -> m1_grant=1 in the next cycle, with no gap and no overlap.
REQ-033 Granted m1 writes addr 16'h0005, data 32'h0000_0008 -> s0_sel=1, s_wr=1, s_addr=16'h0005, s_din=32'h8 in the same cycle.
REQ-034 Granted m0 reads 16'h0300 with s2_dout=32'hCAFE_0001 -> s2_sel=1, and m_din=32'hCAFE_0001 on the following cycle.
REQ-035 Granted master reads 16'h0A00 -> no select asserted, and m_din=0 on the following cycle.
REQ-036 Reset asserted while GNT1 is active during a write -> grants, selects and s_wr go to 0 asynchronously before the next clock edge.
